univ_mod_counter: RTL and testbench

UNIV_MOD_COUNTER -- requirements
Module: univ_mod_counter

---
 rtl/univ_cnt_defs.sv | 20 ++
 rtl/cnt_prescaler.sv | 32 +++
 rtl/univ_mod_counter.sv | 142 ++++++++++++++
 tb/tb_univ_mod_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/univ_cnt_defs.sv
// Shared counter definitions: counting-mode and one-shot state encodings
// used by univ_mod_counter and by later counter blocks.
package univ_cnt_defs;

  // Counting behaviour selected by the 2-bit mode input.
  // The reserved code 2'b11 behaves exactly like MODE_WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } cnt_mode_e;

  // One-shot controller: RUN counts, DONE freezes until clear or load.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } os_state_e;

endpackage

// File: rtl/cnt_prescaler.sv
// Enabled-cycle prescaler: step fires on every (prescale+1)-th enabled cycle.
module cnt_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [PW-1:0] prescale,
  output logic          step
);

  localparam logic [PW-1:0] ONE_PW = PW'(1);

  logic [PW-1:0] pre_q;

  // Using >= rather than == means a prescale value lowered below the running
  // count fires on the very next enabled cycle instead of waiting for rollover.
  assign step = en && (pre_q >= prescale);

  // Count enabled cycles; restart after each step or on a clear request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else if (clr) begin
      pre_q <= '0;
    end else if (en) begin
      pre_q <= step ? '0 : pre_q + ONE_PW;
    end
  end

endmodule

// File: rtl/univ_mod_counter.sv
// Universal modulo counter: wrap / saturate / one-shot modes, programmable
// limit register, enabled-cycle prescaler and a registered wrap pulse.
module univ_mod_counter
  import univ_cnt_defs::*;
#(
  parameter int N  = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          syn_clear,
  input  logic          load,
  input  logic [N-1:0]  d,
  input  logic          en,
  input  logic          up,
  input  logic [1:0]    mode,
  input  logic          limit_we,
  input  logic [N-1:0]  limit_d,
  input  logic [PW-1:0] prescale,
  output logic [N-1:0]  q,
  output logic [N-1:0]  limit,
  output logic          max_tick,
  output logic          min_tick,
  output logic          wrap_tick,
  output logic          done
);

  localparam logic [N-1:0] ONE_N = N'(1);

  cnt_mode_e     mode_e;
  os_state_e     state_q;
  logic [N-1:0]  count_q, count_d;
  logic [N-1:0]  limit_q;
  logic          wrap_q, wrap_d;
  logic          done_q;
  logic          step;
  logic          hit_term;

  assign mode_e = cnt_mode_e'(mode);

  // Load also restarts the prescaler so the first step after a load is a full period away.
  cnt_prescaler #(.PW(PW)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (syn_clear | load),
    .en       (en),
    .prescale (prescale),
    .step     (step)
  );

  // Next count: clear beats load beats step; steps always see the old limit.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    hit_term = 1'b0;
    if (syn_clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = d;
    end else if (step && (state_q == ST_RUN)) begin
      case (mode_e)
        MODE_SAT, MODE_ONESHOT: begin
          if (up) begin
            count_d = (count_q >= limit_q) ? limit_q : count_q + ONE_N;
          end else begin
            count_d = (count_q == '0) ? '0 : count_q - ONE_N;
          end
          if (mode_e == MODE_ONESHOT) begin
            hit_term = up ? (count_d == limit_q) : (count_d == '0);
          end
        end
        default: begin
          if (up) begin
            if (count_q >= limit_q) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + ONE_N;
            end
          end else begin
            if (count_q == '0) begin
              count_d = limit_q;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - ONE_N;
            end
          end
        end
      endcase
    end
  end

  // Datapath registers; the limit write is independent of clear/load/step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= '1;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      if (limit_we) begin
        limit_q <= limit_d;
      end
    end
  end

  // One-shot FSM with registered done flag; only clear or load leaves DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hit_term) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (syn_clear || load) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q         = count_q;
  assign limit     = limit_q;
  assign max_tick  = (count_q == limit_q);
  assign min_tick  = (count_q == '0);
  assign wrap_tick = wrap_q;
  assign done      = done_q;

endmodule

// File: tb/tb_univ_mod_counter.sv
// Scoreboard bench for univ_mod_counter: the driver applies one input vector
// per cycle and queues the behavioural model's expected outputs; a monitor
// pops and compares after every clock edge.
module tb_univ_mod_counter;

  localparam int N   = 4;
  localparam int PW  = 4;
  localparam int TOP = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          syn_clear, load, en, up, limit_we;
  logic [N-1:0]  d, limit_d;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic [N-1:0]  q, limit;
  logic          max_tick, min_tick, wrap_tick, done;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] lim;
    logic         mx;
    logic         mn;
    logic         wr;
    logic         dn;
    int           idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   txn     = 0;

  // Behavioural model: plain integers, prescaler as "enabled cycles waited".
  int m_q, m_lim, m_pre;
  bit m_done, m_wrap;

  univ_mod_counter #(.N(N), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .syn_clear (syn_clear),
    .load      (load),
    .d         (d),
    .en        (en),
    .up        (up),
    .mode      (mode),
    .limit_we  (limit_we),
    .limit_d   (limit_d),
    .prescale  (prescale),
    .q         (q),
    .limit     (limit),
    .max_tick  (max_tick),
    .min_tick  (min_tick),
    .wrap_tick (wrap_tick),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_lim = TOP; m_pre = 0; m_done = 0; m_wrap = 0;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cycle(input bit clr, input bit ld, input int dv, input bit e,
                       input bit u, input int md, input bit lwe, input int lv,
                       input int ps);
    bit   fire;
    exp_t ex;
    @(negedge clk);
    syn_clear = clr; load = ld; d = N'(dv); en = e; up = u; mode = 2'(md);
    limit_we = lwe; limit_d = N'(lv); prescale = PW'(ps);
    fire   = 0;
    m_wrap = 0;
    if (clr) begin
      m_q = 0; m_pre = 0; m_done = 0;
    end else if (ld) begin
      m_q = dv & TOP; m_pre = 0; m_done = 0;
    end else if (e) begin
      if (m_pre < ps) m_pre = m_pre + 1;
      else begin m_pre = 0; fire = 1; end
    end
    if (fire && !m_done) begin
      if (md == 0 || md == 3) begin
        if (u) begin
          if (m_q >= m_lim) begin m_q = 0; m_wrap = 1; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0) begin m_q = m_lim; m_wrap = 1; end
          else m_q = m_q - 1;
        end
      end else begin
        if (u) m_q = (m_q >= m_lim) ? m_lim : m_q + 1;
        else   m_q = (m_q == 0) ? 0 : m_q - 1;
        if (md == 2 && m_q == (u ? m_lim : 0)) m_done = 1;
      end
    end
    if (lwe) m_lim = lv & TOP;
    ex.q   = N'(m_q);
    ex.lim = N'(m_lim);
    ex.mx  = (m_q == m_lim);
    ex.mn  = (m_q == 0);
    ex.wr  = m_wrap;
    ex.dn  = m_done;
    ex.idx = txn;
    txn++;
    exp_q.push_back(ex);
  endtask

  // Pulse reset between edges and check it acts without a clock edge.
  task automatic pulse_reset_check(input string tag);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (q !== '0 || done !== 1'b0 || limit !== N'(TOP) || wrap_tick !== 1'b0 ||
        min_tick !== 1'b1 || max_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got q=%0d done=%0b limit=%0d wrap=%0b min=%0b max=%0b, need q=0 done=0 limit=%0d wrap=0 min=1 max=0",
               tag, q, done, limit, wrap_tick, min_tick, max_tick, TOP);
    end else begin
      $display("[TB] %s: async reset ok", tag);
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Monitor: every clock edge presents a new output set; check it against the queue.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        n_tests++;
        if (q !== ex.q || limit !== ex.lim || max_tick !== ex.mx || min_tick !== ex.mn ||
            wrap_tick !== ex.wr || done !== ex.dn) begin
          n_fail++;
          $display("FAIL txn%0d: got q=%0d lim=%0d max=%0b min=%0b wrap=%0b done=%0b, need q=%0d lim=%0d max=%0b min=%0b wrap=%0b done=%0b",
                   ex.idx, q, limit, max_tick, min_tick, wrap_tick, done,
                   ex.q, ex.lim, ex.mx, ex.mn, ex.wr, ex.dn);
        end else begin
          $display("[TB] txn%0d q=%0d lim=%0d max=%0b min=%0b wrap=%0b done=%0b ok",
                   ex.idx, q, limit, max_tick, min_tick, wrap_tick, done);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int cur_ps;
    reset = 1'b1; syn_clear = 0; load = 0; d = '0; en = 0; up = 1; mode = 2'b00;
    limit_we = 0; limit_d = '0; prescale = '0;
    model_reset();
    #12;
    n_tests++;
    if (q !== '0 || limit !== N'(TOP) || max_tick !== 1'b0 || min_tick !== 1'b1 ||
        wrap_tick !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%0d lim=%0d max=%0b min=%0b wrap=%0b done=%0b, need q=0 lim=%0d max=0 min=1 wrap=0 done=0",
               q, limit, max_tick, min_tick, wrap_tick, done, TOP);
    end else begin
      $display("[TB] reset state ok");
    end
    #1 reset = 1'b0;

    // WRAP up to limit 9
    cycle(0,0,0,0,1,0,1,9,0);
    repeat (12) cycle(0,0,0,1,1,0,0,0,0);
    // WRAP down from 0 with limit 5
    cycle(0,1,0,0,0,0,1,5,0);
    repeat (3) cycle(0,0,0,1,0,0,0,0,0);
    // SAT up with prescale 2 from 14
    cycle(0,1,14,0,1,1,1,15,2);
    repeat (8) cycle(0,0,0,1,1,1,0,0,2);
    // ONESHOT up to limit 3, hold, reload, re-terminate, mode change keeps done
    cycle(1,0,0,0,1,2,1,3,0);
    repeat (5) cycle(0,0,0,1,1,2,0,0,0);
    cycle(0,1,1,0,1,2,0,0,0);
    repeat (3) cycle(0,0,0,1,1,2,0,0,0);
    repeat (2) cycle(0,0,0,1,1,0,0,0,0);
    // ONESHOT down to 0
    cycle(0,1,2,0,0,2,0,0,0);
    repeat (3) cycle(0,0,0,1,0,2,0,0,0);
    // Limit lowered below q, then step wraps
    cycle(0,1,7,0,1,0,1,15,0);
    cycle(0,0,0,0,1,0,1,2,0);
    cycle(0,0,0,1,1,0,0,0,0);
    // Limit write in the same cycle as a step: step uses the old limit
    cycle(0,1,7,0,1,0,1,15,0);
    cycle(0,0,0,1,1,0,1,2,0);
    cycle(0,0,0,1,1,0,0,0,0);
    // Consecutive wraps with limit 0, and reserved mode behaving as WRAP
    cycle(0,0,0,0,1,0,1,0,0);
    repeat (3) cycle(0,0,0,1,1,0,0,0,0);
    repeat (2) cycle(0,0,0,1,1,3,0,0,0);
    // Prescale lowered below the running prescaler count
    cycle(0,1,0,0,1,0,1,15,6);
    repeat (4) cycle(0,0,0,1,1,0,0,0,6);
    repeat (3) cycle(0,0,0,1,1,0,0,0,1);
    // Clear beats load, then reach DONE and reset between edges
    cycle(1,1,6,1,1,0,1,15,0);
    cycle(0,0,0,1,1,2,1,3,0);
    repeat (3) cycle(0,0,0,1,1,2,0,0,0);
    pulse_reset_check("reset_in_done");

    cur_ps = 0;
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) begin
        cur_ps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      end
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), cur_ps);
      if ($urandom_range(0, 149) == 0) pulse_reset_check("reset_random");
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
